card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
- Consumer side of the deck interface: drives shuffle/draw requests into the card deck and routes each drawn card to a player or the board.
- Runs one Texas Hold'em hand: shuffle, hole cards round-robin, then flop/turn/river on request, with burns optional.
- Sits between the game controller (new_hand/deal_next) and the card deck.

Parameters:
- NUM_PLAYERS, 4, seated players; legal range 2..8.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- new_hand  input  1  pulse: abort any hand and start a new one
- deal_next  input  1  pulse: deal next street (flop, turn, river)
- deck_ready  input  1  deck shuffled and drawable
- top_card  input  card_t  current top card of deck (combinational from deck)
- start_shuffle  output  1  one-cycle shuffle request to deck
- draw_card  output  1  advance deck top index this cycle
- card_valid  output  1  card_out/card_dest/card_slot valid this cycle
- card_out  output  card_t  dealt card (= top_card when card_valid)
- card_dest  output  4  player index 0..NUM_PLAYERS-1, or 4'hF = community
- card_slot  output  3  hole slot 0..1 or community slot 0..4
- street  output  3  0 idle, 1 preflop, 2 flop, 3 turn, 4 river
- cards_used  output  6  draws issued this hand, burns included
- busy  output  1  shuffling or dealing (not idle/wait/done)
- hand_done  output  1  level: river dealt, held until new_hand

Behaviour:
- Reset: all outputs 0, card_out 0, FSM IDLE.
- States: IDLE, SHUF_REQ, SHUF_WAIT, HOLE, WAIT_FLOP, FLOP, WAIT_TURN, TURN, WAIT_RIVER, RIVER, DONE.
- IDLE: wait for new_hand -> SHUF_REQ.
- SHUF_REQ: start_shuffle=1 for exactly one cycle; cards_used<=0; street<=0 -> SHUF_WAIT.
- SHUF_WAIT: deck_ready is not sampled on the first cycle, because the deck's ready drops one cycle after the request. From the second cycle, deck_ready=1 -> HOLE.
- Each dealt card takes one cycle: draw_card=1, card_valid=1, card_out=top_card, cards_used+1. Back-to-back draws are legal.
- HOLE: 2*NUM_PLAYERS draws. Draw k goes to card_dest=k mod N, card_slot=k/N. After the last draw: street<=1 -> WAIT_FLOP.
- WAIT_*: idle until deal_next. deal_next in any other state is ignored.
- FLOP: 3 draws to dest F, slots 0,1,2; street<=2 -> WAIT_TURN.
- TURN: 1 draw, slot 3; street<=3 -> WAIT_RIVER.
- RIVER: 1 draw, slot 4; street<=4 -> DONE (hand_done=1).
- Stall: in any dealing state, deck_ready=0 gives draw_card=0 and card_valid=0; the sequence position is held until deck_ready returns.
- new_hand in any state, including mid-deal, goes to SHUF_REQ next cycle. No draw is issued in that cycle. hand_done clears and street<=0.
- new_hand together with deal_next: new_hand wins.
- draw_card is never asserted in IDLE, SHUF_*, WAIT_* or DONE.
- cards_used saturates at 52; it cannot exceed 16+3+5=24 by construction.

Optional Feature:
- Macro: DEALER_BURN_EN.
- Defined:
  - FLOP, TURN and RIVER each begin with one burn cycle: draw_card=1, card_valid=0, cards_used+1.
  - Output burn_pulse (1 bit) is added and asserted on burn cycles.
  - N=4 full hand gives cards_used=16.
- Undefined:
  - No burn cycles and no burn_pulse port.
  - N=4 full hand gives cards_used=13.

Test Plan:
- Reset held low mid-HOLE, then released -> all outputs 0, FSM IDLE, no draw_card until new_hand.
- N=4, new_hand with behavioural deck in new-deck order, no shuffle -> one start_shuffle pulse. After ready, 8 consecutive card_valid cycles with dest 0,1,2,3,0,1,2,3 and slot 0,0,0,0,1,1,1,1. Cards equal deck indices 0..7; street=1.
- From WAIT_FLOP, three deal_next pulses spaced 5 cycles:
  - Without burn: community cards are deck indices 8,9,10 (slots 0-2), then 11 (slot 3), then 12 (slot 4).
  - hand_done=1, street=4, cards_used=13.
- DEALER_BURN_EN defined, same sequence:
  - burn_pulse on indices 8, 12, 14.
  - Board = 9,10,11,13,15; cards_used=16.
- deck_ready forced low for 3 cycles during HOLE after draw 3 -> no draw_card in those cycles. Resumes with dest 3 slot 0; total hole draws still 8.
- new_hand asserted during FLOP second card -> next cycle start_shuffle=1, street=0, cards_used=0, hand_done=0. deal_next asserted in IDLE/SHUF_WAIT is ignored.

Source files
------------

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - Hold'em hand sequencer between game control and card deck; DEALER_BURN_EN adds burn cycles
package card_dealer_pkg;
    typedef logic [5:0] card_t;
endpackage

module card_dealer
    import card_dealer_pkg::*;
#(
    parameter int NUM_PLAYERS = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_new_hand,
    input  logic       i_deal_next,
    input  logic       i_deck_ready,
    input  card_t      i_top_card,
    output logic       o_start_shuffle,
    output logic       o_draw_card,
    output logic       o_card_valid,
    output card_t      o_card_out,
    output logic [3:0] o_card_dest,
    output logic [2:0] o_card_slot,
    output logic [2:0] o_street,
    output logic [5:0] o_cards_used,
    output logic       o_busy,
`ifdef DEALER_BURN_EN
    output logic       o_burn_pulse,
`endif
    output logic       o_hand_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_SHUF_REQ, S_SHUF_WAIT, S_HOLE, S_WAIT_FLOP, S_FLOP,
        S_WAIT_TURN, S_TURN, S_WAIT_RIVER, S_RIVER, S_DONE
    } state_t;

`ifdef DEALER_BURN_EN
    localparam logic L_BURN = 1'b1;
`else
    localparam logic L_BURN = 1'b0;
`endif
    localparam logic [3:0] L_NP        = 4'(NUM_PLAYERS);
    localparam logic [3:0] L_HOLE_LAST = 4'(2 * NUM_PLAYERS - 1);
    localparam logic [3:0] L_BURN4     = {3'b000, L_BURN};
    localparam logic [2:0] L_BURN3     = {2'b00, L_BURN};
    localparam logic [3:0] L_FLOP_LAST = 4'd2 + L_BURN4;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_idx;
    logic        r_first;
    logic [5:0]  r_cards_used;
    logic [2:0]  r_street;
    logic        w_draw;
    logic        w_burn;
    logic        w_valid;
    logic        w_seg_end;
    logic [3:0]  w_dest;
    logic [2:0]  w_slot;

    // r_idx is the draw position inside the current dealing state, burn included
    always_comb begin
        w_next    = r_state;
        w_draw    = 1'b0;
        w_burn    = 1'b0;
        w_seg_end = 1'b0;
        w_dest    = 4'd0;
        w_slot    = 3'd0;
        case (r_state)
            S_IDLE:       if (i_new_hand) w_next = S_SHUF_REQ;
            S_SHUF_REQ:   w_next = S_SHUF_WAIT;
            S_SHUF_WAIT:  if (!r_first && i_deck_ready) w_next = S_HOLE;
            S_HOLE: begin
                w_draw    = i_deck_ready;
                w_dest    = (r_idx >= L_NP) ? r_idx - L_NP : r_idx;
                w_slot    = (r_idx >= L_NP) ? 3'd1 : 3'd0;
                w_seg_end = (r_idx == L_HOLE_LAST);
                if (w_draw && w_seg_end) w_next = S_WAIT_FLOP;
            end
            S_WAIT_FLOP:  if (i_deal_next) w_next = S_FLOP;
            S_FLOP: begin
                w_draw    = i_deck_ready;
                w_burn    = L_BURN && (r_idx == 4'd0);
                w_dest    = 4'hF;
                w_slot    = r_idx[2:0] - L_BURN3;
                w_seg_end = (r_idx == L_FLOP_LAST);
                if (w_draw && w_seg_end) w_next = S_WAIT_TURN;
            end
            S_WAIT_TURN:  if (i_deal_next) w_next = S_TURN;
            S_TURN: begin
                w_draw    = i_deck_ready;
                w_burn    = L_BURN && (r_idx == 4'd0);
                w_dest    = 4'hF;
                w_slot    = 3'd3;
                w_seg_end = (r_idx == L_BURN4);
                if (w_draw && w_seg_end) w_next = S_WAIT_RIVER;
            end
            S_WAIT_RIVER: if (i_deal_next) w_next = S_RIVER;
            S_RIVER: begin
                w_draw    = i_deck_ready;
                w_burn    = L_BURN && (r_idx == 4'd0);
                w_dest    = 4'hF;
                w_slot    = 3'd4;
                w_seg_end = (r_idx == L_BURN4);
                if (w_draw && w_seg_end) w_next = S_DONE;
            end
            default: w_next = r_state;
        endcase
        // A new hand preempts everything, including a draw already on the deck's top
        if (i_new_hand) begin
            w_next = S_SHUF_REQ;
            w_draw = 1'b0;
        end
    end

    assign w_valid = w_draw && !w_burn;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 4'd0;
            r_first      <= 1'b0;
            r_cards_used <= 6'd0;
            r_street     <= 3'd0;
        end else begin
            r_state <= w_next;
            r_first <= (r_state == S_SHUF_REQ);
            if (w_next != r_state) begin
                r_idx <= 4'd0;
            end else if (w_draw) begin
                r_idx <= r_idx + 4'd1;
            end
            if (i_new_hand || r_state == S_SHUF_REQ) begin
                r_cards_used <= 6'd0;
                r_street     <= 3'd0;
            end else if (w_draw) begin
                if (r_cards_used != 6'd52) r_cards_used <= r_cards_used + 6'd1;
                if (w_seg_end) r_street <= r_street + 3'd1;
            end
        end
    end

    assign o_start_shuffle = (r_state == S_SHUF_REQ);
    assign o_draw_card     = w_draw;
    assign o_card_valid    = w_valid;
    assign o_card_out      = w_valid ? i_top_card : '0;
    assign o_card_dest     = w_valid ? w_dest : 4'd0;
    assign o_card_slot     = w_valid ? w_slot : 3'd0;
    assign o_street        = r_street;
    assign o_cards_used    = r_cards_used;
    assign o_busy          = (r_state == S_SHUF_REQ) || (r_state == S_SHUF_WAIT) ||
                             (r_state == S_HOLE) || (r_state == S_FLOP) ||
                             (r_state == S_TURN) || (r_state == S_RIVER);
    assign o_hand_done     = (r_state == S_DONE);
`ifdef DEALER_BURN_EN
    assign o_burn_pulse    = w_draw && w_burn;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - randomized bench for card_dealer against an event-queue hand model
module tb_card_dealer;
    import card_dealer_pkg::*;

    localparam int N = 4;
`ifdef DEALER_BURN_EN
    localparam int BURN = 1;
`else
    localparam int BURN = 0;
`endif
    localparam int M_IDLE = 0, M_REQ = 1, M_SWAIT = 2, M_DEAL = 3, M_WAIT = 4, M_DONE = 5;

    typedef struct packed {
        logic [3:0] dest;
        logic [2:0] slot;
        logic       burn;
        logic       last;
    } ev_t;

    logic clk = 1'b0, rst_n = 1'b0, new_hand = 1'b0, deal_next = 1'b0, deck_ready = 1'b1;
    card_t top_card, card_out;
    logic start_shuffle, draw_card, card_valid, busy, hand_done, burn_pulse;
    logic [3:0] card_dest;
    logic [2:0] card_slot, street;
    logic [5:0] cards_used;

    card_dealer #(.NUM_PLAYERS(N)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_new_hand(new_hand), .i_deal_next(deal_next),
        .i_deck_ready(deck_ready), .i_top_card(top_card),
        .o_start_shuffle(start_shuffle), .o_draw_card(draw_card), .o_card_valid(card_valid),
        .o_card_out(card_out), .o_card_dest(card_dest), .o_card_slot(card_slot),
        .o_street(street), .o_cards_used(cards_used), .o_busy(busy),
`ifdef DEALER_BURN_EN
        .o_burn_pulse(burn_pulse),
`endif
        .o_hand_done(hand_done)
    );
`ifndef DEALER_BURN_EN
    assign burn_pulse = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // deck environment
    card_t deck_arr[52];
    int ptr = 0, shuf_left = 0, force_left = 0;
    bit saw_shuffle = 0, saw_draw = 0, rand_deck = 0, rand_stall = 0;
    bit stall3_mode = 0, stall_used = 0, in_force = 0, resume_chk = 0;
    assign top_card = deck_arr[ptr];

    initial begin
        for (int i = 0; i < 52; i++) deck_arr[i] = card_t'(i);
        forever begin
            @(posedge clk);
            #1;
            if (saw_shuffle) begin
                ptr = 0;
                shuf_left = $urandom_range(1, 4);
                stall_used = 0;
                if (rand_deck) begin
                    for (int i = 51; i > 0; i--) begin
                        int j;
                        card_t t;
                        j = $urandom_range(0, i);
                        t = deck_arr[i]; deck_arr[i] = deck_arr[j]; deck_arr[j] = t;
                    end
                end
            end else if (saw_draw) begin
                ptr++;
            end
            if (stall3_mode && !stall_used && ptr == 3 && shuf_left == 0) begin
                force_left = 3;
                stall_used = 1;
            end
            resume_chk = in_force && (force_left == 0);
            in_force = (force_left > 0);
            if (force_left > 0) begin
                deck_ready = 1'b0;
                force_left--;
            end else if (shuf_left > 0) begin
                deck_ready = 1'b0;
                shuf_left--;
            end else begin
                deck_ready = !(rand_stall && $urandom_range(0, 4) == 0);
            end
        end
    end

    // behavioural model: a hand is an ordered list of draws released street by street
    int m_mode = M_IDLE, m_used = 0, m_street = 0;
    bit m_first = 0;
    ev_t q[$];

    function automatic ev_t mk(input int d, input int s, input bit b, input bit l);
        ev_t e;
        e.dest = 4'(d); e.slot = 3'(s); e.burn = b; e.last = l;
        return e;
    endfunction

    task automatic build_hand();
        q.delete();
        for (int k = 0; k < 2 * N; k++) q.push_back(mk(k % N, k / N, 0, k == 2 * N - 1));
        if (BURN != 0) q.push_back(mk(0, 0, 1, 0));
        for (int s = 0; s < 3; s++) q.push_back(mk(15, s, 0, s == 2));
        for (int s = 3; s < 5; s++) begin
            if (BURN != 0) q.push_back(mk(0, 0, 1, 0));
            q.push_back(mk(15, s, 0, 1));
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = M_IDLE; m_used = 0; m_street = 0; q.delete();
        end else if (new_hand) begin
            m_mode = M_REQ; m_used = 0; m_street = 0;
        end else begin
            case (m_mode)
                M_REQ:   begin build_hand(); m_mode = M_SWAIT; m_first = 1; end
                M_SWAIT: if (m_first) m_first = 0; else if (deck_ready) m_mode = M_DEAL;
                M_DEAL:  if (deck_ready && q.size() > 0) begin
                    ev_t e;
                    e = q.pop_front();
                    if (m_used < 52) m_used++;
                    if (e.last) begin
                        m_street++;
                        m_mode = (m_street == 4) ? M_DONE : M_WAIT;
                    end
                end
                M_WAIT:  if (deal_next) m_mode = M_DEAL;
                default: ;
            endcase
        end
    end

    // per-cycle compare plus capture for literal checks
    bit cap_en = 0;
    int cap_n = 0, burn_n = 0, hole_cnt = 0;
    int cap_card[32], cap_dest[32], cap_slot[32], cap_burn[8];

    initial forever begin
        bit ex_draw, ex_valid;
        ev_t e;
        @(negedge clk);
        ex_draw = (m_mode == M_DEAL) && deck_ready && !new_hand && q.size() > 0;
        e = ex_draw ? q[0] : '0;
        ex_valid = ex_draw && !e.burn;
        chk("start_shuffle", int'(start_shuffle), int'(m_mode == M_REQ));
        chk("draw_card", int'(draw_card), int'(ex_draw));
        chk("card_valid", int'(card_valid), int'(ex_valid));
`ifdef DEALER_BURN_EN
        chk("burn_pulse", int'(burn_pulse), int'(ex_draw && e.burn));
`endif
        chk("card_out", int'(card_out), ex_valid ? int'(deck_arr[m_used]) : 0);
        chk("card_dest", int'(card_dest), ex_valid ? int'(e.dest) : 0);
        chk("card_slot", int'(card_slot), ex_valid ? int'(e.slot) : 0);
        chk("street", int'(street), m_street);
        chk("cards_used", int'(cards_used), m_used);
        chk("hand_done", int'(hand_done), int'(m_mode == M_DONE));
        chk("busy", int'(busy), int'(m_mode == M_REQ || m_mode == M_SWAIT || m_mode == M_DEAL));
        if (in_force) chk("stall_no_draw", int'(draw_card), 0);
        if (resume_chk) begin
            chk("resume_valid", int'(card_valid), 1);
            chk("resume_dest", int'(card_dest), 3);
            chk("resume_slot", int'(card_slot), 0);
        end
        if (start_shuffle) hole_cnt = 0;
        else if (card_valid && card_dest != 4'hF) hole_cnt++;
        if (cap_en && card_valid && cap_n < 32) begin
            cap_card[cap_n] = int'(card_out);
            cap_dest[cap_n] = int'(card_dest);
            cap_slot[cap_n] = int'(card_slot);
            cap_n++;
        end
        if (cap_en && draw_card && !card_valid && burn_n < 8) begin
            cap_burn[burn_n] = int'(cards_used);
            burn_n++;
        end
        saw_shuffle = start_shuffle;
        saw_draw = draw_card;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_new_hand();
        new_hand = 1'b1;
        step();
        new_hand = 1'b0;
    endtask

    task automatic wait_not_busy(input int bound);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while (busy && c < bound);
        chk("wait_bound_busy", int'(busy), 0);
    endtask

    task automatic deal_street();
        deal_next = 1'b1;
        step();
        deal_next = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        int board[5];
        bit found;
        repeat (4) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_cards_used", int'(cards_used), 0);
        deal_next = 1'b1;
        step();
        deal_next = 1'b0;
        step();
        chk("idle_deal_next_busy", int'(busy), 0);
        chk("idle_deal_next_street", int'(street), 0);

        // hand 1: new-deck order, no stalls
        cap_en = 1;
        pulse_new_hand();
        wait_not_busy(100);
        chk("h1_street_hole", int'(street), 1);
        chk("h1_used_hole", int'(cards_used), 8);
        repeat (3) deal_street();
        cap_en = 0;
        chk("h1_done", int'(hand_done), 1);
        chk("h1_street", int'(street), 4);
        chk("h1_used", int'(cards_used), 13 + 3 * BURN);
        chk("h1_valid_count", cap_n, 13);
        for (int i = 0; i < 8; i++) begin
            chk("h1_hole_card", cap_card[i], i);
            chk("h1_hole_dest", cap_dest[i], i % 4);
            chk("h1_hole_slot", cap_slot[i], i / 4);
        end
        if (BURN != 0) board = '{9, 10, 11, 13, 15};
        else board = '{8, 9, 10, 11, 12};
        for (int i = 0; i < 5; i++) begin
            chk("h1_board_card", cap_card[8 + i], board[i]);
            chk("h1_board_dest", cap_dest[8 + i], 15);
            chk("h1_board_slot", cap_slot[8 + i], i);
        end
        chk("h1_burn_count", burn_n, 3 * BURN);
        if (BURN != 0) begin
            chk("h1_burn0", cap_burn[0], 8);
            chk("h1_burn1", cap_burn[1], 12);
            chk("h1_burn2", cap_burn[2], 14);
        end

        // hand 2: forced 3-cycle stall after the third hole card, deal_next during shuffle
        stall3_mode = 1;
        pulse_new_hand();
        deal_next = 1'b1;
        step();
        deal_next = 1'b0;
        wait_not_busy(100);
        stall3_mode = 0;
        chk("h2_hole_cnt", hole_cnt, 8);
        chk("h2_used", int'(cards_used), 8);
        chk("h2_street", int'(street), 1);

        // hand 3: abort on the second flop card
        deal_next = 1'b1;
        step();
        deal_next = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (card_valid && card_dest == 4'hF && card_slot == 3'd1) found = 1;
            else step();
        end
        chk("h3_found_flop2", int'(found), 1);
        new_hand = 1'b1;
        #1;
        chk("h3_abort_no_draw", int'(draw_card), 0);
        step();
        new_hand = 1'b0;
        chk("h3_start_shuffle", int'(start_shuffle), 1);
        chk("h3_street", int'(street), 0);
        chk("h3_used", int'(cards_used), 0);
        chk("h3_done", int'(hand_done), 0);
        deal_next = 1'b1;
        step();
        deal_next = 1'b0;
        wait_not_busy(100);
        chk("h3_used_hole", int'(cards_used), 8);

        // reset mid-hole
        pulse_new_hand();
        for (int c = 0; c < 50 && cards_used < 6'd3; c++) step();
        chk("h4_reached_hole", int'(cards_used >= 6'd3), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_draw", int'(draw_card), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_used", int'(cards_used), 0);
        chk("rst_street", int'(street), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("post_rst_busy", int'(busy), 0);

        // randomized hands
        rand_deck = 1;
        rand_stall = 1;
        for (int h = 0; h < 15; h++) begin
            pulse_new_hand();
            for (int c = 0; c < 80; c++) begin
                deal_next = ($urandom_range(0, 3) == 0);
                new_hand = ($urandom_range(0, 150) == 0);
                step();
            end
            deal_next = 1'b0;
            new_hand = 1'b0;
        end
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
